// File: rtl/rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : rd_arbiter_pkg
// Brief  : Shared constants for the two-requester AXI read arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package rd_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [2:0] ARSIZE_WORD  = 3'd2;
  localparam logic [3:0] ID_D_DEFAULT = 4'd0;
  localparam logic [3:0] ID_I_DEFAULT = 4'd1;

  // One-hot grant encoding: bit 0 = D side, bit 1 = I side
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_D    = 2'b01;
  localparam logic [1:0] GNT_I    = 2'b10;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_arb_pick.sv
`default_nettype none
// ============================================================================
// Module : rd_arb_pick
// Brief  : Combinational winner selection; round-robin when
//          RD_ARB_ROUND_ROBIN_EN is defined, fixed D-over-I priority otherwise.
// Rev    : 1.0 - initial release
// ============================================================================
module rd_arb_pick
  import rd_arbiter_pkg::*;
(
  input  logic       d_req,
  input  logic       i_req,
  input  logic       ptr,
  output logic [1:0] gnt
);

`ifdef RD_ARB_ROUND_ROBIN_EN
  // ptr names the side preferred when both request
  always_comb begin
    gnt = GNT_NONE;
    if (d_req && i_req)
      gnt = ptr ? GNT_I : GNT_D;
    else if (d_req)
      gnt = GNT_D;
    else if (i_req)
      gnt = GNT_I;
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ptr;

  always_comb begin
    gnt = GNT_NONE;
    if (d_req)
      gnt = GNT_D;
    else if (i_req)
      gnt = GNT_I;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rd_arbiter
// Brief  : Grants one AXI read transaction at a time to the D or I cache,
//          steers R beats back by grant and flags beat-count/ID errors.
//          Define RD_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Rev    : 1.0 - initial release
// ============================================================================
module rd_arbiter
  import rd_arbiter_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] ID_D   = ID_D_DEFAULT,
  parameter logic [3:0] ID_I   = ID_I_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [3:0]        d_arlen,
  input  logic              d_arvalid,
  output logic              d_arready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_rlast,
  input  logic              d_rready,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [3:0]        i_arlen,
  input  logic              i_arvalid,
  output logic              i_arready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_rlast,
  input  logic              i_rready,
  output logic [3:0]        m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [3:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [3:0]        m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rvalid,
  input  logic              m_rlast,
  output logic              m_rready,
  output logic              busy,
  output logic              err
);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_len;
  logic [3:0]        r_id;
  logic              r_side;   // 0 = D granted, 1 = I granted
  logic [3:0]        r_cnt;
  logic              r_err;

  logic [1:0]        w_gnt;
  logic              w_ptr;
  logic              w_idle;
  logic              w_data;
  logic              w_accept;
  logic              w_rhs;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_data   = (r_state == ST_DATA);
  assign w_accept = w_idle && !reset && (d_arvalid || i_arvalid);
  assign w_rhs    = w_data && m_rvalid && m_rready;

  rd_arb_pick u_pick (
    .d_req (d_arvalid),
    .i_req (i_arvalid),
    .ptr   (w_ptr),
    .gnt   (w_gnt)
  );

`ifdef RD_ARB_ROUND_ROBIN_EN
  logic r_ptr;
  // After a grant, the side that lost becomes preferred
  always_ff @(posedge clk) begin
    if (reset)
      r_ptr <= 1'b0;
    else if (w_accept)
      r_ptr <= ~w_gnt[1];
  end
  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_id    <= '0;
      r_side  <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_side  <= w_gnt[1];
            r_addr  <= w_gnt[1] ? i_araddr : d_araddr;
            r_len   <= w_gnt[1] ? i_arlen  : d_arlen;
            r_id    <= w_gnt[1] ? ID_I     : ID_D;
            r_cnt   <= '0;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_arready)
            r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (w_rhs) begin
            r_cnt <= sat_inc4(r_cnt);
            // r_cnt is the index of the beat being accepted
            if ((m_rid != r_id) ||
                (m_rlast && (r_cnt != r_len)) ||
                (!m_rlast && (r_cnt == r_len)))
              r_err <= 1'b1;
            if (m_rlast)
              r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign d_arready = w_accept && w_gnt[0];
  assign i_arready = w_accept && w_gnt[1];

  assign m_arid    = r_id;
  assign m_araddr  = r_addr;
  assign m_arlen   = r_len;
  assign m_arsize  = ARSIZE_WORD;
  assign m_arvalid = (r_state == ST_ADDR);

  assign m_rready  = w_data && (r_side ? i_rready : d_rready);

  assign d_rvalid  = w_data && !r_side && m_rvalid;
  assign d_rlast   = w_data && !r_side && m_rlast;
  assign d_rdata   = (w_data && !r_side) ? m_rdata : '0;
  assign i_rvalid  = w_data && r_side && m_rvalid;
  assign i_rlast   = w_data && r_side && m_rlast;
  assign i_rdata   = (w_data && r_side) ? m_rdata : '0;

  assign busy      = !w_idle;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_rd_arbiter
// Brief  : Scoreboard bench for rd_arbiter with randomized transactions.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_rd_arbiter;

  localparam int         ADDR_W = 32;
  localparam int         DATA_W = 32;
  localparam logic [3:0] TB_ID_D = 4'd0;
  localparam logic [3:0] TB_ID_I = 4'd1;
`ifdef RD_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [ADDR_W-1:0] d_araddr, i_araddr, m_araddr;
  logic [3:0]  d_arlen, i_arlen, m_arlen, m_arid, m_rid;
  logic        d_arvalid, d_arready, d_rvalid, d_rlast, d_rready;
  logic        i_arvalid, i_arready, i_rvalid, i_rlast, i_rready;
  logic [DATA_W-1:0] d_rdata, i_rdata, m_rdata;
  logic [2:0]  m_arsize;
  logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready, busy, err;

  rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_D(TB_ID_D), .ID_I(TB_ID_I)) dut (
    .clk(clk), .reset(reset),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rready(d_rready),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rready(i_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [3:0] len; } ar_t;
  typedef struct packed { logic [31:0] data; logic last; } beat_t;

  ar_t        ar_q[$];
  beat_t      dq[$];
  beat_t      iq[$];
  logic [1:0] g_q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  logic err_exp = 1'b0;
  bit   pref_i  = 1'b0;
  bit   acc_prev = 1'b0;
  beat_t mon_b;
  logic [1:0] mon_g;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  task automatic flush_model();
    ar_q.delete(); dq.delete(); iq.delete(); g_q.delete();
    err_exp = 1'b0; pref_i = 1'b0; acc_prev = 1'b0;
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents an output
  always @(negedge clk) begin
    if (!reset) begin
      if (d_arready || i_arready) begin
        if (g_q.size() == 0) fail_evt("unexpected_grant");
        else begin
          mon_g = g_q.pop_front();
          chk("grant", {62'd0, i_arready, d_arready}, {62'd0, mon_g});
        end
      end else if (acc_prev) begin
        chk("arvalid_latency", {63'd0, m_arvalid}, 64'd1);
      end
      acc_prev = d_arready || i_arready;
      if (m_arvalid) begin
        if (ar_q.size() == 0) fail_evt("unexpected_ar");
        else begin
          chk("ar_fields", {21'd0, m_arid, m_araddr, m_arlen, m_arsize},
              {21'd0, ar_q[0].id, ar_q[0].addr, ar_q[0].len, 3'd2});
          if (m_arready) ar_q.delete(0);
        end
      end
      if (d_rvalid && i_rvalid) fail_evt("both_rvalid");
      if (d_rvalid) begin
        if (dq.size() == 0) fail_evt("unexpected_d_beat");
        else if (d_rready) begin
          mon_b = dq.pop_front();
          chk("d_beat", {31'd0, d_rdata, d_rlast}, {31'd0, mon_b});
        end
      end
      if (i_rvalid) begin
        if (iq.size() == 0) fail_evt("unexpected_i_beat");
        else if (i_rready) begin
          mon_b = iq.pop_front();
          chk("i_beat", {31'd0, i_rdata, i_rlast}, {31'd0, mon_b});
        end
      end
      if (m_rvalid) chk("m_rready", {63'd0, m_rready}, {63'd0, d_rready | i_rready});
      chk("err", {63'd0, err}, {63'd0, err_exp});
    end
  end

  task automatic check_zero(input string name);
    @(negedge clk);
    chk({name, "_ctrl"}, {54'd0, busy, err, m_arvalid, m_rready, d_arready, i_arready,
                          d_rvalid, d_rlast, i_rvalid, i_rlast}, 64'd0);
    chk({name, "_ar"}, {24'd0, m_arid, m_araddr, m_arlen}, 64'd0);
    chk({name, "_rdata"}, {d_rdata, i_rdata}, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    d_arvalid = 0; i_arvalid = 0; d_rready = 0; i_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rlast = 0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    flush_model();
    check_zero("reset");
  endtask

  // kind: 0 legal, 1 wrong RID on first beat, 2 RLAST one beat early,
  //       3 RLAST missing on final beat (sent one beat late)
  task automatic do_txn(input bit rd, input bit ri, input logic [31:0] ad, input logic [31:0] ai,
                        input logic [3:0] ld, input logic [3:0] li, input int ar_dly,
                        input int kind, input int abort_at);
    bit win_i;
    logic [3:0] id, len, rid;
    int nb;
    ar_t a;
    beat_t bt;
    if (rd && ri) win_i = RR_EN ? pref_i : 1'b0;
    else          win_i = ri;
    id  = win_i ? TB_ID_I : TB_ID_D;
    len = win_i ? li : ld;
    a.id = id; a.addr = win_i ? ai : ad; a.len = len;
    ar_q.push_back(a);
    g_q.push_back(win_i ? 2'b10 : 2'b01);
    d_arvalid = rd; d_araddr = ad; d_arlen = ld;
    i_arvalid = ri; i_araddr = ai; i_arlen = li;
    @(negedge clk);
    if (!(d_arready || i_arready)) begin
      fail_evt("accept_timeout");
      d_arvalid = 0; i_arvalid = 0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    d_arvalid = 0; i_arvalid = 0;
    if (RR_EN) pref_i = !win_i;
    repeat (ar_dly) begin @(posedge clk); #1; end
    m_arready = 1'b1;
    @(posedge clk); #1;
    m_arready = 1'b0;
    nb = (kind == 2) ? int'(len) : (kind == 3) ? int'(len) + 2 : int'(len) + 1;
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      bt.data = $urandom;
      bt.last = (b == nb - 1);
      rid = (kind == 1 && b == 0) ? (id ^ 4'h1) : id;
      m_rvalid = 1'b1; m_rdata = bt.data; m_rlast = bt.last; m_rid = rid;
      if (b == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; m_rvalid = 0; m_rlast = 0; m_rid = 0;
        flush_model();
        check_zero("abort");
        return;
      end
      if (win_i) iq.push_back(bt); else dq.push_back(bt);
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      if (win_i) i_rready = 1'b1; else d_rready = 1'b1;
      @(posedge clk); #1;
      if ((rid != id) || (bt.last && b != int'(len)) || (!bt.last && b == int'(len)))
        err_exp = 1'b1;
      d_rready = 0; i_rready = 0; m_rvalid = 0; m_rlast = 0;
      if (kind == 3 && b == int'(len)) chk("stay_in_data", {63'd0, busy}, 64'd1);
    end
    chk("idle_after_last", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int r;
    d_araddr = 0; d_arlen = 0; i_araddr = 0; i_arlen = 0;
    m_rid = 0; m_rdata = 0;
    do_reset();

    do_txn(1, 0, 32'h1FC0_0100, 32'h0, 4'd0, 4'd0, 0, 0, -1);
    do_txn(0, 1, 32'h0, 32'h0000_1000, 4'd0, 4'd3, 3, 0, -1);
    repeat (4) do_txn(1, 1, $urandom, $urandom, 4'($urandom_range(0, 3)),
                      4'($urandom_range(0, 3)), $urandom_range(0, 2), 0, -1);
    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(1, 3);
      do_txn(r[0], r[1], $urandom, $urandom, 4'($urandom_range(0, 7)),
             4'($urandom_range(0, 7)), $urandom_range(0, 3), 0, -1);
    end

    do_txn(1, 0, 32'h2000_0040, 32'h0, 4'd1, 4'd0, 0, 1, -1);
    repeat (2) begin @(posedge clk); #1; end
    do_reset();
    do_txn(0, 1, 32'h0, 32'h0000_2000, 4'd0, 4'd3, 1, 2, -1);
    repeat (3) begin @(posedge clk); #1; end
    do_reset();
    do_txn(1, 0, 32'h3000_0000, 32'h0, 4'd1, 4'd0, 0, 3, -1);
    do_reset();
    do_txn(1, 0, 32'h4000_0000, 32'h0, 4'd3, 4'd0, 0, 0, 2);
    do_txn(1, 0, 32'h4000_0100, 32'h0, 4'd0, 4'd0, 0, 0, -1);

    repeat (2) begin @(posedge clk); #1; end
    chk("ar_q_drained", 64'(ar_q.size()), 64'd0);
    chk("d_q_drained", 64'(dq.size()), 64'd0);
    chk("i_q_drained", 64'(iq.size()), 64'd0);
    chk("g_q_drained", 64'(g_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
